dvp_stream_rx: RTL and testbench

//  Parametrised DVP camera receiver. Packs BYTES_PER_PIXEL beats into one pixel word.

---
 rtl/dvp_pkg.sv | 27 ++
 rtl/dvp_sync_fifo.sv | 75 +++++++
 rtl/dvp_stream_rx.sv | 212 +++++++++++++++++++++
 tb/tb_dvp_stream_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP receiver: polarity constants, FIFO word layout,
// receive-control states and a constant clog2 helper.
package dvp_pkg;

    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // FIFO word layout: {tdata, tuser, tlast}
    localparam int unsigned FIFO_LAST_BIT = 0;
    localparam int unsigned FIFO_USER_BIT = 1;
    localparam int unsigned FIFO_DATA_LSB = 2;

    typedef enum logic [1:0] {
        ST_DROP   = 2'd0,
        ST_SOF    = 2'd1,
        ST_STREAM = 2'd2
    } rx_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dvp_sync_fifo.sv
// Single-clock FIFO with a registered head word; rd_valid/full are registered flags.
module dvp_sync_fifo
    import dvp_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        do_rd     = rd_en && rd_valid;
        do_wr     = wr_en && (!full || do_rd);
        rd_ptr_nx = AW'(rd_ptr + 1'b1);
        count_d   = count;
        if (do_wr && !do_rd) begin
            count_d = CW'(count + 1'b1);
        end else if (!do_wr && do_rd) begin
            count_d = CW'(count - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head register tracks mem[rd_ptr]; a write into an empty (or emptying) FIFO bypasses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr_nx;
            end
            count    <= count_d;
            rd_valid <= (count_d != '0);
            full     <= (count_d == CW'(DEPTH));
            if (do_wr && ((count == '0) || ((count == CW'(1)) && do_rd))) begin
                rd_data <= wr_data;
            end else if (do_rd && (count > CW'(1))) begin
                rd_data <= mem[rd_ptr_nx];
            end
        end
    end

endmodule

// File: rtl/dvp_stream_rx.sv
// DVP camera receiver: packs sensor beats into pixels, tags frame start / line end,
// and queues them onto an AXI4-Stream master while measuring line/frame geometry.
module dvp_stream_rx
    import dvp_pkg::*;
#(
    parameter int unsigned DIN_WIDTH         = 8,
    parameter int unsigned BYTES_PER_PIXEL   = 2,
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b0,
    parameter bit          HREF_ACTIVE_HIGH  = 1'b1,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned CNT_WIDTH         = 12
) (
    input  logic                                   pclk,
    input  logic                                   rst_n,
    input  logic [DIN_WIDTH-1:0]                   din,
    input  logic                                   href_in,
    input  logic                                   vsync_in,
    output logic [DIN_WIDTH*BYTES_PER_PIXEL-1:0]   m_axis_tdata,
    output logic                                   m_axis_tuser,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [CNT_WIDTH-1:0]                   line_pixels,
    output logic [CNT_WIDTH-1:0]                   frame_lines,
    output logic                                   frame_done,
    output logic                                   overflow,
    output logic                                   partial_err
);

    localparam int unsigned PIX_W  = DIN_WIDTH * BYTES_PER_PIXEL;
    localparam int unsigned WORD_W = PIX_W + FIFO_DATA_LSB;
    localparam int unsigned BC_W   = (BYTES_PER_PIXEL > 1) ? clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [BC_W-1:0]      BC_LAST = BC_W'(BYTES_PER_PIXEL - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 href_act;
    logic                 vsync_act;
    logic [DIN_WIDTH-1:0] din_q;
    logic                 href_q;
    logic                 href_qq;
    logic                 vs_q;
    logic                 vs_qq;
    logic                 vs_edge;
    logic                 href_fall;
    logic                 beat;
    logic                 pix_done;

    logic [BC_W-1:0]      byte_cnt;
    logic [PIX_W-1:0]     asm_q;
    logic [PIX_W-1:0]     asm_next;
    logic [PIX_W-1:0]     pend_q;
    logic                 pend_valid;
    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [CNT_WIDTH-1:0] line_cnt;

    rx_state_e            state_q;
    rx_state_e            state_d;
    logic                 emit;
    logic                 emit_last;
    logic                 wr_req;
    logic                 wr_en;
    logic                 ovf_now;
    logic                 pop;
    logic                 fifo_full;
    logic [WORD_W-1:0]    wr_data;
    logic [WORD_W-1:0]    fifo_rd_data;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : CNT_WIDTH'(v + 1'b1);
    endfunction

    assign href_act  = (HREF_ACTIVE_HIGH == POL_ACTIVE_HIGH) ? href_in : ~href_in;
    assign vsync_act = (VSYNC_ACTIVE_HIGH == POL_ACTIVE_HIGH) ? vsync_in : ~vsync_in;

    // Input stage; vsync history resets to "blanking" so only a genuine edge starts a frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            din_q   <= '0;
            href_q  <= 1'b0;
            href_qq <= 1'b0;
            vs_q    <= 1'b1;
            vs_qq   <= 1'b1;
        end else begin
            din_q   <= din;
            href_q  <= href_act;
            href_qq <= href_q;
            vs_q    <= vsync_act;
            vs_qq   <= vs_q;
        end
    end

    assign vs_edge   = vs_q && !vs_qq;
    assign href_fall = href_qq && !href_q;
    assign beat      = href_q && !vs_edge;
    assign pix_done  = beat && (byte_cnt == BC_LAST);
    assign asm_next  = PIX_W'({asm_q, din_q});
    assign pop       = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DROP;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending-pixel emission, FIFO write/overflow decision and receive-control next state.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        wr_req    = 1'b0;
        wr_en     = 1'b0;
        ovf_now   = 1'b0;
        wr_data   = '0;

        emit      = pend_valid && (vs_edge || href_fall || pix_done);
        emit_last = vs_edge || href_fall;
        wr_req    = emit && (state_q != ST_DROP);
        wr_en     = wr_req && (!fifo_full || pop);
        ovf_now   = wr_req && fifo_full && !pop;

        wr_data[WORD_W-1:FIFO_DATA_LSB] = pend_q;
        wr_data[FIFO_USER_BIT]          = (state_q == ST_SOF);
        wr_data[FIFO_LAST_BIT]          = emit_last;

        if (vs_edge) begin
            state_d = ST_SOF;
        end else if (ovf_now) begin
            state_d = ST_DROP;
        end else if ((state_q == ST_SOF) && wr_en) begin
            state_d = ST_STREAM;
        end
    end

    // Pending register: a dropped frame never loads, but emission always retires it.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_valid <= 1'b0;
        end else if (pix_done && (state_q != ST_DROP)) begin
            pend_q     <= asm_next;
            pend_valid <= 1'b1;
        end else if (emit) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            asm_q       <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_pixels <= '0;
            frame_lines <= '0;
            frame_done  <= 1'b0;
            partial_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            partial_err <= 1'b0;
            if (ovf_now) begin
                overflow <= 1'b1;
            end
            if (vs_edge) begin
                frame_done  <= 1'b1;
                frame_lines <= line_cnt;
                line_cnt    <= '0;
                pix_cnt     <= '0;
                byte_cnt    <= '0;
            end else if (href_fall) begin
                if (byte_cnt != '0) begin
                    partial_err <= 1'b1;
                end
                byte_cnt <= '0;
                if (pix_cnt != '0) begin
                    line_pixels <= pix_cnt;
                    line_cnt    <= sat_inc(line_cnt);
                end
                pix_cnt <= '0;
            end else if (beat) begin
                asm_q <= asm_next;
                if (pix_done) begin
                    byte_cnt <= '0;
                    pix_cnt  <= sat_inc(pix_cnt);
                end else begin
                    byte_cnt <= BC_W'(byte_cnt + 1'b1);
                end
            end
        end
    end

    dvp_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (pclk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .rd_valid (m_axis_tvalid),
        .full     (fifo_full)
    );

    assign m_axis_tdata = fifo_rd_data[WORD_W-1:FIFO_DATA_LSB];
    assign m_axis_tuser = fifo_rd_data[FIFO_USER_BIT];
    assign m_axis_tlast = fifo_rd_data[FIFO_LAST_BIT];

endmodule

// File: tb/tb_dvp_stream_rx.sv
// Bench for dvp_stream_rx: default instance (BPP=2) plus an inverted-polarity BPP=1 instance.
module tb_dvp_stream_rx;

    logic        pclk;
    logic        rst_n;
    logic [7:0]  din;
    logic        href, vsync, href2, vsync2, tready;

    logic [15:0] tdata;
    logic        tuser, tlast, tvalid;
    logic [11:0] line_pixels, frame_lines;
    logic        frame_done, overflow, partial_err;

    logic [7:0]  t2data;
    logic        t2user, t2last, t2valid;
    logic [11:0] lp2, fl2;
    logic        fd2, ov2, pe2;

    int n_cmp = 0;
    int n_err = 0;
    int n_fd  = 0;
    int n_pe  = 0;
    logic [17:0] q[$];
    logic [9:0]  q2[$];
    bit sof1 = 1'b0;
    bit sof2 = 1'b0;
    bit drive2 = 1'b0;

    typedef struct {
        bit         is_vsync;
        int         beats;
        logic [7:0] base;
        int         exp_cnt;
        int         exp_perr;
    } vec_t;
    vec_t vecs[9];

    dvp_stream_rx dut (
        .pclk(pclk), .rst_n(rst_n), .din(din), .href_in(href), .vsync_in(vsync),
        .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .line_pixels(line_pixels), .frame_lines(frame_lines), .frame_done(frame_done),
        .overflow(overflow), .partial_err(partial_err)
    );

    dvp_stream_rx #(
        .BYTES_PER_PIXEL(1), .VSYNC_ACTIVE_HIGH(1'b1), .HREF_ACTIVE_HIGH(1'b0)
    ) dut2 (
        .pclk(pclk), .rst_n(rst_n), .din(din), .href_in(href2), .vsync_in(vsync2),
        .m_axis_tdata(t2data), .m_axis_tuser(t2user), .m_axis_tlast(t2last),
        .m_axis_tvalid(t2valid), .m_axis_tready(1'b1),
        .line_pixels(lp2), .frame_lines(fl2), .frame_done(fd2),
        .overflow(ov2), .partial_err(pe2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Output monitor: scoreboard pops on handshake, head word checked while stalled.
    always @(negedge pclk) begin
        if (rst_n) begin
            if (tvalid && tready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut1_extra_word: got %0h required no word", {tdata, tuser, tlast});
                end else begin
                    check("dut1_word", 32'({tdata, tuser, tlast}), 32'(q.pop_front()));
                end
            end else if (tvalid && q.size() != 0) begin
                check("dut1_hold", 32'({tdata, tuser, tlast}), 32'(q[0]));
            end
            if (t2valid) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut2_extra_word: got %0h required no word", {t2data, t2user, t2last});
                end else begin
                    check("dut2_word", 32'({t2data, t2user, t2last}), 32'(q2.pop_front()));
                end
            end
            if (frame_done)  n_fd++;
            if (partial_err) n_pe++;
        end
    end

    task automatic frame_edge();
        vsync = 1'b0;
        if (drive2) vsync2 = 1'b1;
        repeat (3) tick();
        vsync  = 1'b1;
        vsync2 = 1'b0;
        repeat (3) tick();
        sof1 = 1'b1;
        if (drive2) sof2 = 1'b1;
    endtask

    // Drives one line; expects at most max_push complete pixels from the default instance.
    task automatic drive_line(input int beats, input logic [7:0] base, input int max_push);
        int full;
        int npush;
        full  = beats / 2;
        npush = (full < max_push) ? full : max_push;
        for (int k = 0; k < npush; k++) begin
            q.push_back({8'(base + 2 * k), 8'(base + 2 * k + 1), sof1 && (k == 0), k == full - 1});
        end
        if (npush > 0) sof1 = 1'b0;
        if (drive2) begin
            for (int i = 0; i < beats; i++) begin
                q2.push_back({8'(base + i), sof2 && (i == 0), i == beats - 1});
            end
            sof2 = 1'b0;
        end
        for (int i = 0; i < beats; i++) begin
            din  = 8'(base + i);
            href = 1'b1;
            if (drive2) href2 = 1'b0;
            tick();
        end
        href  = 1'b0;
        href2 = 1'b1;
        din   = 8'h00;
        repeat (4) tick();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || q2.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        check("drain_left", 32'(q.size() + q2.size()), 32'd0);
        repeat (5) tick();
    endtask

    initial begin
        int fd0, pe0;
        vecs[0] = '{1'b1, 0, 8'h00, 1, 0};
        vecs[1] = '{1'b0, 8, 8'h01, 4, 0};
        vecs[2] = '{1'b0, 8, 8'h01, 4, 0};
        vecs[3] = '{1'b0, 8, 8'h01, 4, 0};
        vecs[4] = '{1'b1, 0, 8'h00, 3, 0};
        vecs[5] = '{1'b0, 5, 8'h10, 2, 1};
        vecs[6] = '{1'b0, 2, 8'h20, 1, 0};
        vecs[7] = '{1'b0, 7, 8'h30, 3, 1};
        vecs[8] = '{1'b1, 0, 8'h00, 3, 0};

        rst_n = 1'b0; din = 8'h00; href = 1'b0; vsync = 1'b1;
        href2 = 1'b1; vsync2 = 1'b0; tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_word", 32'({tdata, tuser, tlast}), 32'd0);
        check("rst_counts", 32'({line_pixels, frame_lines}), 32'd0);
        check("rst_flags", 32'({frame_done, overflow, partial_err}), 32'd0);
        check("rst_tvalid2", 32'(t2valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Before the first frame edge nothing may be delivered.
        drive_line(8, 8'hA0, 0);
        repeat (6) tick();
        drive2 = 1'b1;

        for (int i = 0; i < 9; i++) begin
            fd0 = n_fd;
            pe0 = n_pe;
            if (vecs[i].is_vsync) begin
                frame_edge();
                check("frame_lines", 32'(frame_lines), 32'(vecs[i].exp_cnt));
                check("frame_done", 32'(n_fd - fd0), 32'd1);
            end else begin
                drive_line(vecs[i].beats, vecs[i].base, 99);
                check("line_pixels", 32'(line_pixels), 32'(vecs[i].exp_cnt));
                check("partial_err", 32'(n_pe - pe0), 32'(vecs[i].exp_perr));
            end
            if (i == 4) drive2 = 1'b0;
        end
        wait_drain();

        // Backpressure for a whole line: words held, then released in order.
        tready = 1'b0;
        drive_line(8, 8'h40, 99);
        repeat (6) tick();
        check("stall_tvalid", 32'(tvalid), 32'd1);
        check("stall_queued", 32'(q.size()), 32'd4);
        check("stall_overflow", 32'(overflow), 32'd0);
        tready = 1'b1;
        wait_drain();

        // Overflow: 16 words kept, rest of frame dropped, next frame intact.
        tready = 1'b0;
        drive_line(40, 8'h50, 16);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_line_pixels", 32'(line_pixels), 32'd20);
        drive_line(8, 8'h90, 0);
        tready = 1'b1;
        wait_drain();
        fd0 = n_fd;
        frame_edge();
        check("ovf_frame_done", 32'(n_fd - fd0), 32'd1);
        drive_line(8, 8'hC0, 99);
        wait_drain();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-line with three words queued.
        tready = 1'b0;
        drive_line(6, 8'h70, 99);
        for (int i = 0; i < 3; i++) begin
            din = 8'(8'hE0 + i);
            href = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_tvalid", 32'(tvalid), 32'd0);
        check("rst_mid_word", 32'({tdata, tuser, tlast}), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        q.delete();
        sof1 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 3; i < 6; i++) begin
            din = 8'(8'hE0 + i);
            href = 1'b1;
            tick();
        end
        href = 1'b0;
        repeat (4) tick();
        tready = 1'b1;
        repeat (10) tick();
        check("post_rst_idle", 32'(tvalid), 32'd0);
        frame_edge();
        drive_line(8, 8'hB0, 99);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
